// File: rtl/ex_div_unit_if.sv
// ex_div_unit_if: execute-stage hookup between the pipeline (master) and the divide engine (slave)
// Signals: start_E, funct3_E, Src_A_E, Src_B_E, RD_E, flush_E (pipeline -> divider);
//          StallE, busy, done, Div_ResultE, RD_DivE (divider -> pipeline).
interface ex_div_unit_if #(
  parameter int XLEN = 32
);
  logic            start_E;
  logic [2:0]      funct3_E;
  logic [XLEN-1:0] Src_A_E;
  logic [XLEN-1:0] Src_B_E;
  logic [4:0]      RD_E;
  logic            flush_E;
  logic            StallE;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] Div_ResultE;
  logic [4:0]      RD_DivE;
  modport master (
    output start_E, funct3_E, Src_A_E, Src_B_E, RD_E, flush_E,
    input  StallE, busy, done, Div_ResultE, RD_DivE
  );
  modport slave (
    input  start_E, funct3_E, Src_A_E, Src_B_E, RD_E, flush_E,
    output StallE, busy, done, Div_ResultE, RD_DivE
  );
endinterface

// File: rtl/ex_div_unit.sv
// ex_div_unit: iterative restoring RV32M DIV/DIVU/REM/REMU engine beside the EX-stage ALU
// Ports: clk (rising edge), rst (asynchronous, active-low),
//        bus (ex_div_unit_if.slave): start_E/funct3_E/Src_A_E/Src_B_E/RD_E/flush_E in,
//        StallE (combinational), busy, done (1-cycle pulse), Div_ResultE, RD_DivE out.
// Optional: define DIV_EARLY_OUT_EN to finish in one cycle when |dividend| < |divisor|.
module ex_div_unit #(
  parameter int XLEN = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input logic clk,
  input logic rst,
  ex_div_unit_if.slave bus
);
  localparam int N = XLEN / BITS_PER_CYCLE;
  localparam int CW = $clog2(N + 1);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [XLEN-1:0] rem, quo, dvs, result, a_mag, b_mag, rem_nx, quo_nx, q_fix, r_fix, quick_res;
  logic [XLEN:0] sh, trial;
  logic [4:0] rd;
  logic done_r, neg_q, neg_r, is_rem, go, is_signed, a_neg, b_neg, div_zero, ovf, early;
  // only funct3 encodings 1xx are divides; bit 0 selects unsigned, bit 1 selects remainder
  always_comb begin
    go = bus.start_E & !bus.flush_E & bus.funct3_E[2];
    is_signed = !bus.funct3_E[0];
    a_neg = is_signed & bus.Src_A_E[XLEN-1];
    b_neg = is_signed & bus.Src_B_E[XLEN-1];
    a_mag = a_neg ? -bus.Src_A_E : bus.Src_A_E;
    b_mag = b_neg ? -bus.Src_B_E : bus.Src_B_E;
    div_zero = bus.Src_B_E == '0;
    ovf = is_signed & (bus.Src_A_E == {1'b1, {(XLEN-1){1'b0}}}) & (&bus.Src_B_E);
`ifdef DIV_EARLY_OUT_EN
    early = a_mag < b_mag;
`else
    early = 1'b0;
`endif
    quick_res = div_zero ? (bus.funct3_E[1] ? bus.Src_A_E : '1) :
                ovf      ? (bus.funct3_E[1] ? '0 : bus.Src_A_E) :
                           (bus.funct3_E[1] ? bus.Src_A_E : '0);
  end
  // restoring step: the partial remainder never reaches the divisor, so XLEN bits hold it
  // and one extra bit on the trial subtraction serves as the borrow
  always_comb begin
    rem_nx = rem;
    quo_nx = quo;
    sh = '0;
    trial = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      sh = {rem_nx, quo_nx[XLEN-1]};
      trial = sh - {1'b0, dvs};
      rem_nx = trial[XLEN] ? sh[XLEN-1:0] : trial[XLEN-1:0];
      quo_nx = {quo_nx[XLEN-2:0], !trial[XLEN]};
    end
    q_fix = neg_q ? -quo_nx : quo_nx;
    r_fix = neg_r ? -rem_nx : rem_nx;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      rem <= '0;
      quo <= '0;
      dvs <= '0;
      result <= '0;
      rd <= '0;
      done_r <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      is_rem <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (bus.flush_E) state <= IDLE;
      else if (state == IDLE && go) begin
        rd <= bus.RD_E;
        is_rem <= bus.funct3_E[1];
        neg_q <= a_neg ^ b_neg;
        neg_r <= a_neg;
        rem <= '0;
        quo <= a_mag;
        dvs <= b_mag;
        cnt <= CW'(N);
        if (div_zero || ovf || early) begin
          result <= quick_res;
          done_r <= 1'b1;
          state <= DONE;
        end else state <= CALC;
      end else if (state == CALC) begin
        rem <= rem_nx;
        quo <= quo_nx;
        cnt <= cnt - 1'b1;
        if (cnt == CW'(1)) begin
          result <= is_rem ? r_fix : q_fix;
          done_r <= 1'b1;
          state <= DONE;
        end
      end else if (state == DONE) state <= IDLE;
    end
  end
  assign bus.StallE = rst & (((state == IDLE) & go) | (state == CALC));
  assign bus.busy = state != IDLE;
  assign bus.done = done_r;
  assign bus.Div_ResultE = result;
  assign bus.RD_DivE = rd;
endmodule

// File: tb/tb_ex_div_unit.sv
// tb_ex_div_unit: directed checks of ex_div_unit at BITS_PER_CYCLE 1 and 4
module tb_ex_div_unit;
  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
  } vec_t;
`ifdef DIV_EARLY_OUT_EN
  localparam int EO_LAT = 1;
`else
  localparam int EO_LAT = 33;
`endif
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic flush = 1'b0;
  logic sel = 1'b0;
  logic [2:0] f3 = '0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [4:0] rd = '0;
  logic stall_o, busy_o, done_o;
  logic [31:0] res_o;
  logic [4:0] rd_o;
  int total = 0;
  int bad = 0;
  ex_div_unit_if #(.XLEN(32)) if1 ();
  ex_div_unit_if #(.XLEN(32)) if4 ();
  assign if1.start_E = start & !sel;
  assign if1.flush_E = flush & !sel;
  assign if1.funct3_E = f3;
  assign if1.Src_A_E = a;
  assign if1.Src_B_E = b;
  assign if1.RD_E = rd;
  assign if4.start_E = start & sel;
  assign if4.flush_E = flush & sel;
  assign if4.funct3_E = f3;
  assign if4.Src_A_E = a;
  assign if4.Src_B_E = b;
  assign if4.RD_E = rd;
  assign stall_o = sel ? if4.StallE : if1.StallE;
  assign busy_o = sel ? if4.busy : if1.busy;
  assign done_o = sel ? if4.done : if1.done;
  assign res_o = sel ? if4.Div_ResultE : if1.Div_ResultE;
  assign rd_o = sel ? if4.RD_DivE : if1.RD_DivE;
  ex_div_unit #(.XLEN(32), .BITS_PER_CYCLE(1)) u1 (.clk(clk), .rst(rst), .bus(if1));
  ex_div_unit #(.XLEN(32), .BITS_PER_CYCLE(4)) u4 (.clk(clk), .rst(rst), .bus(if4));
  always #5 clk = ~clk;
  // Starts one op in the current cycle T; lat counts edges until done (done at T+lat),
  // stl counts StallE-high cycles from T through the done cycle. A nonzero flush_at raises
  // flush_E during cycle T+flush_at and the op is abandoned at T+flush_at+1.
  task automatic do_op(input logic s, input logic [2:0] f, input logic [31:0] x, input logic [31:0] y,
                       input logic [4:0] r, input int flush_at, output logic got, output int lat,
                       output int stl, output logic [31:0] res, output logic [4:0] rdo,
                       output logic [31:0] held, output logic quiet);
    sel = s; f3 = f; a = x; b = y; rd = r; flush = 1'b0; start = 1'b1;
    got = 1'b0; lat = 0; stl = 0; res = '0; rdo = '0; held = '0; quiet = 1'b0;
    #1 stl += int'(stall_o);
    while (!got && lat < 100 && !(flush_at > 0 && lat > flush_at)) begin
      @(posedge clk);
      #2 lat++;
      start = 1'b0;
      flush = (lat == flush_at);
      #1 stl += int'(stall_o);
      if (done_o) begin
        got = 1'b1;
        res = res_o;
        rdo = rd_o;
      end
    end
    flush = 1'b0;
    if (flush_at > 0) begin
      quiet = !busy_o && !got;
      held = res_o;
    end else begin
      @(posedge clk);
      #3 quiet = !done_o && !busy_o;
      held = res_o;
    end
  endtask
  task automatic test_reset();
    total++;
    if (if1.StallE !== 1'b0 || if4.StallE !== 1'b0) begin
      bad++; $display("FAIL reset_stall got=%b/%b exp=0/0", if1.StallE, if4.StallE);
    end
    total++;
    if ({if1.busy, if1.done, if4.busy, if4.done} !== 4'b0) begin
      bad++; $display("FAIL reset_busy_done got=%b exp=0000", {if1.busy, if1.done, if4.busy, if4.done});
    end
    total++;
    if (if1.Div_ResultE !== 32'h0 || if1.RD_DivE !== 5'h0) begin
      bad++; $display("FAIL reset_result got=%h/%h exp=0/0", if1.Div_ResultE, if1.RD_DivE);
    end
  endtask
  task automatic test_unsigned();
    vec_t v[2];
    logic got, quiet; int lat, stl; logic [31:0] res, held; logic [4:0] rdo;
    v[0] = '{3'b101, 32'd100, 32'd7, 32'd14};
    v[1] = '{3'b111, 32'd100, 32'd7, 32'd2};
    for (int i = 0; i < 2; i++) begin
      do_op(1'b0, v[i].f, v[i].a, v[i].b, 5'(i + 3), 0, got, lat, stl, res, rdo, held, quiet);
      total++;
      if (!got || lat !== 33) begin bad++; $display("FAIL unsigned[%0d]_latency got=%0d/%b exp=33", i, lat, got); end
      total++;
      if (stl !== 33) begin bad++; $display("FAIL unsigned[%0d]_stall_cycles got=%0d exp=33", i, stl); end
      total++;
      if (res !== v[i].q) begin bad++; $display("FAIL unsigned[%0d]_result got=%h exp=%h", i, res, v[i].q); end
      total++;
      if (rdo !== 5'(i + 3)) begin bad++; $display("FAIL unsigned[%0d]_rd got=%0d exp=%0d", i, rdo, i + 3); end
      total++;
      if (!quiet || held !== v[i].q) begin bad++; $display("FAIL unsigned[%0d]_after_done quiet=%b held=%h exp=1/%h", i, quiet, held, v[i].q); end
    end
  endtask
  task automatic test_signed();
    vec_t v[4];
    logic got, quiet; int lat, stl; logic [31:0] res, held; logic [4:0] rdo;
    v[0] = '{3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD};
    v[1] = '{3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF};
    v[2] = '{3'b100, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD};
    v[3] = '{3'b110, 32'd7, 32'hFFFFFFFE, 32'd1};
    for (int i = 0; i < 4; i++) begin
      do_op(1'b0, v[i].f, v[i].a, v[i].b, 5'd7, 0, got, lat, stl, res, rdo, held, quiet);
      total++;
      if (!got || lat !== 33) begin bad++; $display("FAIL signed[%0d]_latency got=%0d/%b exp=33", i, lat, got); end
      total++;
      if (res !== v[i].q) begin bad++; $display("FAIL signed[%0d]_result got=%h exp=%h", i, res, v[i].q); end
    end
  endtask
  task automatic test_special();
    vec_t v[6];
    logic got, quiet; int lat, stl; logic [31:0] res, held; logic [4:0] rdo;
    v[0] = '{3'b101, 32'd5, 32'd0, 32'hFFFFFFFF};
    v[1] = '{3'b111, 32'd5, 32'd0, 32'd5};
    v[2] = '{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000};
    v[3] = '{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0};
    v[4] = '{3'b100, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFF};
    v[5] = '{3'b110, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB};
    for (int i = 0; i < 6; i++) begin
      do_op(1'b0, v[i].f, v[i].a, v[i].b, 5'(20 + i), 0, got, lat, stl, res, rdo, held, quiet);
      total++;
      if (!got || lat !== 1 || stl !== 1) begin bad++; $display("FAIL special[%0d]_timing lat=%0d stall=%0d got=%b exp=1/1", i, lat, stl, got); end
      total++;
      if (res !== v[i].q || rdo !== 5'(20 + i)) begin bad++; $display("FAIL special[%0d]_result got=%h rd=%0d exp=%h rd=%0d", i, res, rdo, v[i].q, 20 + i); end
    end
  endtask
  task automatic test_flush();
    logic got, quiet; int lat, stl; logic [31:0] res, held; logic [4:0] rdo;
    do_op(1'b0, 3'b101, 32'd20, 32'd4, 5'd1, 0, got, lat, stl, res, rdo, held, quiet);
    total++;
    if (!got || res !== 32'd5) begin bad++; $display("FAIL flush_setup got=%h/%b exp=5", res, got); end
    do_op(1'b0, 3'b101, 32'd1000, 32'd3, 5'd2, 10, got, lat, stl, res, rdo, held, quiet);
    total++;
    if (!quiet) begin bad++; $display("FAIL flush_mid_calc busy_or_done got=%b exp=idle_no_done", got); end
    total++;
    if (held !== 32'd5) begin bad++; $display("FAIL flush_mid_calc_held got=%h exp=5", held); end
    do_op(1'b0, 3'b101, 32'd9, 32'd3, 5'd3, 0, got, lat, stl, res, rdo, held, quiet);
    total++;
    if (!got || lat !== 33 || res !== 32'd3) begin bad++; $display("FAIL flush_followup got=%h lat=%0d exp=3 lat=33", res, lat); end
    do_op(1'b0, 3'b101, 32'd1000, 32'd3, 5'd4, 32, got, lat, stl, res, rdo, held, quiet);
    total++;
    if (!quiet || held !== 32'd3) begin bad++; $display("FAIL flush_at_done_edge quiet=%b held=%h exp=1/3", quiet, held); end
  endtask
  task automatic test_back_to_back();
    logic got, quiet; int lat, stl; logic [31:0] res, held; logic [4:0] rdo;
    do_op(1'b0, 3'b101, 32'd45, 32'd5, 5'd10, 0, got, lat, stl, res, rdo, held, quiet);
    total++;
    if (!got || res !== 32'd9 || !quiet) begin bad++; $display("FAIL b2b_first got=%h quiet=%b exp=9/1", res, quiet); end
    do_op(1'b0, 3'b111, 32'd47, 32'd5, 5'd11, 0, got, lat, stl, res, rdo, held, quiet);
    total++;
    if (!got || lat !== 33 || res !== 32'd2 || rdo !== 5'd11) begin bad++; $display("FAIL b2b_second got=%h lat=%0d rd=%0d exp=2/33/11", res, lat, rdo); end
  endtask
  task automatic test_early();
    vec_t v[4];
    logic got, quiet; int lat, stl; logic [31:0] res, held; logic [4:0] rdo;
    v[0] = '{3'b101, 32'd3, 32'd10, 32'd0};
    v[1] = '{3'b111, 32'd3, 32'd10, 32'd3};
    v[2] = '{3'b100, 32'hFFFFFFFD, 32'd10, 32'd0};
    v[3] = '{3'b110, 32'hFFFFFFFD, 32'd10, 32'hFFFFFFFD};
    for (int i = 0; i < 4; i++) begin
      do_op(1'b0, v[i].f, v[i].a, v[i].b, 5'd12, 0, got, lat, stl, res, rdo, held, quiet);
      total++;
      if (!got || lat !== EO_LAT || stl !== EO_LAT) begin bad++; $display("FAIL early[%0d]_timing lat=%0d stall=%0d exp=%0d", i, lat, stl, EO_LAT); end
      total++;
      if (res !== v[i].q) begin bad++; $display("FAIL early[%0d]_result got=%h exp=%h", i, res, v[i].q); end
    end
  endtask
  task automatic test_bpc4();
    vec_t v[3];
    logic got, quiet; int lat, stl; logic [31:0] res, held; logic [4:0] rdo;
    v[0] = '{3'b101, 32'hFFFFFFFF, 32'h10, 32'h0FFFFFFF};
    v[1] = '{3'b111, 32'hFFFFFFFF, 32'h10, 32'hF};
    v[2] = '{3'b100, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2};
    for (int i = 0; i < 3; i++) begin
      do_op(1'b1, v[i].f, v[i].a, v[i].b, 5'd9, 0, got, lat, stl, res, rdo, held, quiet);
      total++;
      if (!got || lat !== 9 || stl !== 9) begin bad++; $display("FAIL bpc4[%0d]_timing lat=%0d stall=%0d exp=9/9", i, lat, stl); end
      total++;
      if (res !== v[i].q) begin bad++; $display("FAIL bpc4[%0d]_result got=%h exp=%h", i, res, v[i].q); end
    end
  endtask
  task automatic test_reset_mid_calc();
    logic got, quiet; int lat, stl; logic [31:0] res, held; logic [4:0] rdo;
    sel = 1'b1; f3 = 3'b101; a = 32'hFFFFFFFF; b = 32'h10; rd = 5'd17; start = 1'b1;
    repeat (4) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    total++;
    if (if4.StallE !== 1'b0 || if4.busy !== 1'b0 || if4.done !== 1'b0) begin
      bad++; $display("FAIL reset_mid_calc_ctrl got=%b%b%b exp=000", if4.StallE, if4.busy, if4.done);
    end
    total++;
    if (if4.Div_ResultE !== 32'h0 || if4.RD_DivE !== 5'h0) begin
      bad++; $display("FAIL reset_mid_calc_data got=%h/%0d exp=0/0", if4.Div_ResultE, if4.RD_DivE);
    end
    start = 1'b0;
    #2 rst = 1'b1;
    @(posedge clk);
    #3;
    do_op(1'b1, 3'b101, 32'd9, 32'd3, 5'd18, 0, got, lat, stl, res, rdo, held, quiet);
    total++;
    if (!got || lat !== 9 || res !== 32'd3) begin bad++; $display("FAIL reset_recover got=%h lat=%0d exp=3/9", res, lat); end
  endtask
  initial begin
    start = 1'b1; f3 = 3'b101; a = 32'd100; b = 32'd7;
    #12;
    test_reset();
    start = 1'b0;
    #1 rst = 1'b1;
    @(posedge clk);
    #3;
    test_unsigned();
    test_signed();
    test_special();
    test_flush();
    test_back_to_back();
    test_early();
    test_bpc4();
    test_reset_mid_calc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
